// File: rtl/regfile_dump_engine.sv
// Sequencer that walks the register file through a spare read port and streams
// index-tagged words out on a valid/ready interface, in address order.
module regfile_dump_engine #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout_data,
    output logic [ADDR_W-1:0] dout_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } stateType;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    stateType          stateReg,     stateNext;
    logic [ADDR_W-1:0] idxReg,       idxNext;
    logic              validReg,     validNext;
    logic [DATA_W-1:0] dataReg,      dataNext;
    logic [ADDR_W-1:0] doutIdxReg,   doutIdxNext;

    logic handshake;
    logic lastWord;

    assign handshake = validReg && dout_ready;
    assign lastWord  = (idxReg == LAST_IDX);

    // State register: every piece of block state lives here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg   <= IDLE;
            idxReg     <= '0;
            validReg   <= 1'b0;
            dataReg    <= '0;
            doutIdxReg <= '0;
        end else begin
            stateReg   <= stateNext;
            idxReg     <= idxNext;
            validReg   <= validNext;
            dataReg    <= dataNext;
            doutIdxReg <= doutIdxNext;
        end
    end

    // Next-state logic.
    always_comb begin
        stateNext = stateReg;
        unique case (stateReg)
            IDLE: begin
                if (start) begin
                    stateNext = READ;
                end
            end
            READ: begin
                stateNext = abort ? IDLE : HOLD;
            end
            HOLD: begin
                if (abort) begin
                    stateNext = IDLE;
                end else if (handshake) begin
                    stateNext = lastWord ? DONE : READ;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Output and datapath logic. The counter stops at LAST_IDX, so it never wraps
    // even when NUM_REGS fills the whole address space.
    always_comb begin
        idxNext     = idxReg;
        validNext   = validReg;
        dataNext    = dataReg;
        doutIdxNext = doutIdxReg;
        busy        = (stateReg != IDLE);
        done        = (stateReg == DONE);
        unique case (stateReg)
            IDLE: begin
                idxNext   = '0;
                validNext = 1'b0;
            end
            READ: begin
                if (abort) begin
                    idxNext   = '0;
                    validNext = 1'b0;
                end else begin
                    dataNext    = rf_rdata;
                    doutIdxNext = idxReg;
                    validNext   = 1'b1;
                end
            end
            HOLD: begin
                if (abort) begin
                    idxNext   = '0;
                    validNext = 1'b0;
                end else if (handshake) begin
                    validNext = 1'b0;
                    if (!lastWord) begin
                        idxNext = idxReg + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                idxNext   = '0;
                validNext = 1'b0;
            end
            default: begin
                idxNext   = '0;
                validNext = 1'b0;
            end
        endcase
    end

    assign rf_raddr   = idxReg;
    assign dout_valid = validReg;
    assign dout_data  = dataReg;
    assign dout_idx   = doutIdxReg;

endmodule

// File: tb/tb_regfile_dump_engine.sv
// Directed bench for regfile_dump_engine: full dumps with and without
// backpressure, abort, asynchronous reset, ignored start and live rf update.
module tb_regfile_dump_engine;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    logic clkTB = 1'b0;
    always #5 clkTB = ~clkTB;

    logic              reset;
    logic              start;
    logic              abort;
    logic              dout_ready;
    logic [ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              dout_valid;
    logic [DATA_W-1:0] dout_data;
    logic [ADDR_W-1:0] dout_idx;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] rfMem   [NUM_REGS];
    logic [DATA_W-1:0] expData [NUM_REGS];

    int compareCount  = 0;
    int mismatchCount = 0;

    assign rf_rdata = rfMem[rf_raddr];

    regfile_dump_engine #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS)
    ) dut (
        .clk       (clkTB),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_data (dout_data),
        .dout_idx  (dout_idx),
        .busy      (busy),
        .done      (done)
    );

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] want);
        compareCount++;
        if (got !== want) begin
            mismatchCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic preload();
        for (int i = 0; i < NUM_REGS; i++) begin
            rfMem[i]   = 32'hA000_0000 + i;
            expData[i] = 32'hA000_0000 + i;
        end
    endtask

    // Runs one full dump from a start pulse and checks every word and the done pulse.
    task automatic runDump(input string name, input int dutyPct, input bit checkTiming,
                           input bit liveUpdate, input bit pokeStart);
        int               cyc;
        int               nextIdx;
        int               doneSeen;
        bit               livePending;
        bit               poked;
        logic             prevValid;
        logic             prevReady;
        logic [DATA_W-1:0] prevData;
        logic [ADDR_W-1:0] prevIdx;
        cyc         = 0;
        nextIdx     = 0;
        doneSeen    = 0;
        livePending = liveUpdate;
        poked       = 1'b0;
        prevValid   = 1'b0;
        prevReady   = 1'b0;
        prevData    = '0;
        prevIdx     = '0;
        @(negedge clkTB);
        start      = 1'b1;
        dout_ready = (dutyPct >= 100);
        while (cyc < 3000) begin
            @(negedge clkTB);
            cyc++;
            start = 1'b0;
            if (cyc == 1) checkVal({name, "_busy_after_start"}, busy, 1);
            if (done && dout_valid) checkVal({name, "_done_valid_excl"}, 1, 0);
            if (prevValid && !prevReady) begin
                checkVal({name, "_stall_valid"}, dout_valid, 1);
                checkVal({name, "_stall_data"}, dout_data, prevData);
                checkVal({name, "_stall_idx"}, dout_idx, prevIdx);
            end else if (dout_valid) begin
                checkVal({name, "_word_idx"}, dout_idx, nextIdx);
                checkVal({name, "_word_data"}, dout_data, expData[nextIdx & (NUM_REGS - 1)]);
                if (checkTiming) checkVal({name, "_word_cycle"}, cyc, 2 + 2 * nextIdx);
            end
            if (done) begin
                doneSeen++;
                if (checkTiming) checkVal({name, "_done_cycle"}, cyc, 1 + 2 * NUM_REGS);
                if (pokeStart) start = 1'b1;
                break;
            end
            if (dutyPct >= 100) dout_ready = 1'b1;
            else dout_ready = ($urandom_range(99) < dutyPct);
            if (livePending && dout_valid && dout_idx == 5'd3) begin
                dout_ready  = 1'b0;
                rfMem[20]   = 32'hDEAD_BEEF;
                expData[20] = 32'hDEAD_BEEF;
                livePending = 1'b0;
            end
            if (pokeStart && !poked && dout_valid && dout_idx == 5'd5) begin
                start = 1'b1;
                poked = 1'b1;
            end
            if (dout_valid && dout_ready) begin
                $display("%s word idx=%0d data=%08h cycle=%0d", name, dout_idx, dout_data, cyc);
                nextIdx++;
            end
            prevValid = dout_valid;
            prevReady = dout_ready;
            prevData  = dout_data;
            prevIdx   = dout_idx;
        end
        checkVal({name, "_words_accepted"}, nextIdx, NUM_REGS);
        checkVal({name, "_done_count"}, doneSeen, 1);
        @(negedge clkTB);
        start = 1'b0;
        checkVal({name, "_idle_after_done"}, busy, 0);
        repeat (4) @(negedge clkTB);
        checkVal({name, "_no_restart_busy"}, busy, 0);
        checkVal({name, "_no_restart_valid"}, dout_valid, 0);
    endtask

    // Starts a dump with ready high and returns once word `target` is presented.
    task automatic reachWord(input int target, output bit found);
        found = 1'b0;
        @(negedge clkTB);
        start      = 1'b1;
        dout_ready = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clkTB);
            start = 1'b0;
            if (dout_valid && dout_idx == target[ADDR_W-1:0]) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit found;
        int doneCount;
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        dout_ready = 1'b0;
        preload();
        repeat (2) @(negedge clkTB);
        checkVal("rst_valid", dout_valid, 0);
        checkVal("rst_data", dout_data, 0);
        checkVal("rst_idx", dout_idx, 0);
        checkVal("rst_raddr", rf_raddr, 0);
        checkVal("rst_busy", busy, 0);
        checkVal("rst_done", done, 0);
        reset = 1'b0;
        repeat (2) @(negedge clkTB);
        checkVal("idle_no_start", busy, 0);

        runDump("basic", 100, 1'b1, 1'b0, 1'b0);
        runDump("bpress", 30, 1'b0, 1'b0, 1'b0);

        reachWord(7, found);
        checkVal("abort_reach_word7", found, 1);
        dout_ready = 1'b0;
        @(negedge clkTB);
        checkVal("abort_held_idx", dout_idx, 7);
        abort = 1'b1;
        @(negedge clkTB);
        abort = 1'b0;
        checkVal("abort_valid", dout_valid, 0);
        checkVal("abort_busy", busy, 0);
        checkVal("abort_raddr", rf_raddr, 0);
        doneCount = done ? 1 : 0;
        repeat (5) begin
            @(negedge clkTB);
            if (done) doneCount++;
        end
        checkVal("abort_no_done", doneCount, 0);
        runDump("restart", 100, 1'b1, 1'b0, 1'b0);

        reachWord(12, found);
        checkVal("rst_reach_word12", found, 1);
        #1 reset = 1'b1;
        #1;
        checkVal("arst_valid", dout_valid, 0);
        checkVal("arst_busy", busy, 0);
        checkVal("arst_raddr", rf_raddr, 0);
        @(negedge clkTB);
        reset = 1'b0;
        repeat (3) @(negedge clkTB);
        checkVal("arst_idle_busy", busy, 0);
        checkVal("arst_idle_valid", dout_valid, 0);
        runDump("postrst", 100, 1'b1, 1'b0, 1'b0);

        runDump("ignstart", 100, 1'b1, 1'b0, 1'b1);
        runDump("live", 100, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/regfile_dump_engine.md
# regfile_dump_engine

Hardware sequencer that reads every entry of the datapath register file through a spare read port and streams the entries out, in address order, on a valid/ready interface. It sits beside `Datapath`, sharing its clock. It is the in-hardware reader of register-file state: a debug/UART/trace consumer gets index-tagged words without hierarchical probing. Each word is held stable until the consumer accepts it.

## Interface

**Parameters**
- `DATA_W`, default 32: register width.
- `ADDR_W`, default 5: register-file address width.
- `NUM_REGS`, default 32: entries dumped, indices 0..NUM_REGS-1. Must satisfy NUM_REGS ≤ 2^ADDR_W.

**Ports**
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `start`  in  1: request a full dump; sampled only in IDLE.
- `abort`  in  1: terminate the dump in progress.
- `rf_raddr`  out  ADDR_W: read address to the register-file read port.
- `rf_rdata`  in  DATA_W: combinational read data for `rf_raddr`.
- `dout_valid`  out  1: `dout_data`/`dout_idx` hold a word.
- `dout_ready`  in  1: consumer accepts the word when it is high together with `dout_valid`.
- `dout_data`  out  DATA_W: register contents.
- `dout_idx`  out  ADDR_W: register index of `dout_data`.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: one-cycle pulse after the last word is accepted.

## Operation

- States: IDLE, READ, HOLD, DONE. Index counter `idx` (ADDR_W bits); `rf_raddr` = `idx` at all times.
- IDLE: `idx`=0.
  - `start`=1 → READ.
  - Otherwise stay in IDLE.
- READ, one cycle:
  - `dout_data`←`rf_rdata` and `dout_idx`←`idx` are registered at the edge.
  - `dout_valid`←1; go to HOLD.
- HOLD:
  - `dout_valid`=1. `dout_data` and `dout_idx` are frozen while `dout_ready`=0.
  - On `dout_valid`&&`dout_ready` with `idx`=NUM_REGS-1: `dout_valid`←0, go to DONE.
  - Else on handshake: `idx`←`idx`+1, `dout_valid`←0, go to READ.
- DONE, one cycle:
  - `done`=1, `idx`←0; go to IDLE.
- `abort`=1 in READ or HOLD:
  - Next state is IDLE; `dout_valid`←0 and `idx`←0.
  - A handshake in the same cycle counts as accepted, but no further word is produced.
  - `done` is not pulsed.
- `abort` in IDLE or DONE has no effect; DONE still pulses `done`.
- `start` is ignored in any state except IDLE. This includes the DONE cycle, so a new dump needs `start` in a later IDLE cycle.
- `idx` never passes NUM_REGS-1, so there is no wrap-around. With NUM_REGS=2^ADDR_W the last index is all-ones and the counter is never incremented past it.
- Register-file contents changing mid-dump: each word reflects `rf_rdata` at its own READ edge. No snapshot is taken.

## Timing

- Reset values: state=IDLE, `idx`=0, `rf_raddr`=0, `dout_valid`=0, `dout_data`=0, `dout_idx`=0, `busy`=0, `done`=0.
- Reset asserted mid-dump: all outputs return to reset values asynchronously. After deassertion the block waits in IDLE for `start`.
- Latency:
  - `start` sampled at edge N; READ during cycle N+1.
  - `dout_valid` rises after edge N+1 with word 0.
- Throughput: 2 cycles per word with `dout_ready` held at 1. A full 32-word dump takes 64 cycles from the READ entry to the last handshake.
- With `dout_ready` tied to 1: `done` is high in the cycle after the last handshake edge, i.e. 1 + 2·NUM_REGS cycles after the `start` edge.
- `done` and `dout_valid` are never high in the same cycle.
- `busy` is registered from state; it is high from the cycle after `start` through the DONE cycle inclusive.

## Test plan

- **Basic dump.** Preload rf[i]=32'hA000_0000+i, hold `dout_ready`=1, pulse `start`. Expect 32 words in order with `dout_idx`=0..31 and `dout_data`=A0000000..A000001F, words spaced 2 cycles apart, and `done` pulsed exactly once, 65 cycles after the `start` edge.
- **Backpressure.** Drive `dout_ready` with a random 30% duty cycle. Expect every word accepted exactly once, `dout_data`/`dout_idx` unchanged while stalled, and the sequence identical to the basic dump.
- **Abort.** Assert `abort` in HOLD with `dout_idx`=7 and `dout_ready`=0. Expect `dout_valid`=0 next cycle, state IDLE, `rf_raddr`=0, and no `done`. A following `start` restarts at index 0.
- **Asynchronous reset.** Assert `reset` between edges during word 12. Expect `dout_valid`, `busy` and `rf_raddr` to go to 0 before the next edge. After release, the block is idle until `start`.
- **Ignored start.** Pulse `start` while busy at word 5, and again in the DONE cycle. Expect the dump to be unaffected and no second dump to begin.
- **Live update.** Write rf[20]=32'hDEAD_BEEF while word 3 is stalled. Expect word 20 to show DEADBEEF.
